// File: rtl/sd_stream_player.sv
// rtl/sd_stream_player.sv - paces FIFO sample reads for the DAC and shares the read port with host byte reads
// Build option PLAYER_UNDERRUN_MUTE_EN: every underrun also forces dac_val to MID_VAL.
module sd_stream_player #(
  parameter int unsigned SAMPLE_DIV = 1134,
  parameter int unsigned DIV_W      = 16,
  parameter logic [7:0]  MID_VAL    = 8'h80
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       play_en,
  input  logic       host_rd,
  output logic [7:0] host_data,
  output logic       host_valid,
  input  logic       fifo_empty,
  output logic       fifo_rd,
  input  logic [7:0] fifo_data,
  output logic [7:0] dac_val,
  output logic [7:0] underrun_cnt,
  input  logic       underrun_clr,
  output logic       busy
);

  typedef enum logic [2:0] {IDLE, REQ_PLAY, CAP_PLAY, REQ_HOST, CAP_HOST} state_t;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);

  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             samp_pend_q, samp_pend_d;
  logic             host_pend_q, host_pend_d;
  logic [7:0]       dac_q, dac_d;
  logic [7:0]       host_data_q, host_data_d;
  logic             host_valid_q, host_valid_d;
  logic [7:0]       urun_q, urun_d;
  logic             tick;
  logic             urun_inc;

  always_comb begin
    div_d = '0;
    tick  = 1'b0;
    if (play_en) begin
      if (div_q == DIV_LAST) tick = 1'b1;
      else                   div_d = div_q + DIV_W'(1);
    end
  end

  always_comb begin
    state_d      = state_q;
    samp_pend_d  = samp_pend_q;
    host_pend_d  = host_pend_q;
    dac_d        = dac_q;
    host_data_d  = host_data_q;
    host_valid_d = 1'b0;
    urun_d       = urun_q;
    // A tick landing on a still-pending sample is a missed deadline.
    urun_inc     = tick && samp_pend_q;

    if (host_rd && !host_pend_q) host_pend_d = 1'b1;

    unique case (state_q)
      IDLE: begin
        if (samp_pend_q && play_en) begin
          samp_pend_d = 1'b0;
          if (fifo_empty) urun_inc = 1'b1;
          else            state_d  = REQ_PLAY;
        end else if (host_pend_q && !fifo_empty) begin
          host_pend_d = 1'b0;
          state_d     = REQ_HOST;
        end
      end
      REQ_PLAY: state_d = CAP_PLAY;
      CAP_PLAY: begin
        dac_d   = fifo_data;
        state_d = IDLE;
      end
      REQ_HOST: state_d = CAP_HOST;
      CAP_HOST: begin
        host_data_d  = fifo_data;
        host_valid_d = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (tick)     samp_pend_d = 1'b1;
    if (!play_en) samp_pend_d = 1'b0;

    if (underrun_clr)                    urun_d = 8'h00;
    else if (urun_inc && urun_q != 8'hFF) urun_d = urun_q + 8'h01;

`ifdef PLAYER_UNDERRUN_MUTE_EN
    if (urun_inc) dac_d = MID_VAL;
`else
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      div_q        <= '0;
      samp_pend_q  <= 1'b0;
      host_pend_q  <= 1'b0;
      dac_q        <= MID_VAL;
      host_data_q  <= 8'h00;
      host_valid_q <= 1'b0;
      urun_q       <= 8'h00;
    end else begin
      state_q      <= state_d;
      div_q        <= div_d;
      samp_pend_q  <= samp_pend_d;
      host_pend_q  <= host_pend_d;
      dac_q        <= dac_d;
      host_data_q  <= host_data_d;
      host_valid_q <= host_valid_d;
      urun_q       <= urun_d;
    end
  end

  assign fifo_rd      = (state_q == REQ_PLAY) || (state_q == REQ_HOST);
  assign busy         = (state_q != IDLE);
  assign dac_val      = dac_q;
  assign host_data    = host_data_q;
  assign host_valid   = host_valid_q;
  assign underrun_cnt = urun_q;

endmodule

// File: tb/tb_sd_stream_player.sv
// tb/tb_sd_stream_player.sv - randomized self-checking bench for sd_stream_player
module tb_sd_stream_player;

  localparam int         DIV = 8;
  localparam logic [7:0] MID = 8'h80;
`ifdef PLAYER_UNDERRUN_MUTE_EN
  localparam bit MUTE = 1'b1;
`else
  localparam bit MUTE = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, play_en, host_rd, underrun_clr;
  logic       fifo_empty, fifo_rd, host_valid, busy;
  logic [7:0] host_data, fifo_data, dac_val, underrun_cnt;

  int         n_cmp = 0;
  int         n_bad = 0;
  int         rd_cnt = 0;
  logic [7:0] fq[$];
  logic [7:0] exp_dac;

  always #5 clk = ~clk;

  sd_stream_player #(.SAMPLE_DIV(DIV), .DIV_W(16), .MID_VAL(MID)) dut (
    .clk(clk), .rst(rst), .play_en(play_en), .host_rd(host_rd),
    .host_data(host_data), .host_valid(host_valid), .fifo_empty(fifo_empty),
    .fifo_rd(fifo_rd), .fifo_data(fifo_data), .dac_val(dac_val),
    .underrun_cnt(underrun_cnt), .underrun_clr(underrun_clr), .busy(busy)
  );

  // FIFO model: data appears the cycle after fifo_rd
  always @(posedge clk) begin
    if (fifo_rd) begin
      rd_cnt <= rd_cnt + 1;
      if (fq.size() != 0) fifo_data <= fq.pop_front();
    end
    fifo_empty <= (fq.size() == 0);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic gap(input int n);
    repeat (n) step();
  endtask

  task automatic host_once(input logic [7:0] b);
    fq.push_back(b);
    gap(2);
    for (int k = 0; k < 8; k++) begin
      if (k > 0) step();
      host_rd = (k == 0);
      @(negedge clk);
      check("host_fifo_rd", fifo_rd, k == 2);
      check("host_busy", busy, (k == 2) || (k == 3));
      check("host_valid", host_valid, k == 4);
      if (k == 4) check("host_data", host_data, b);
    end
  endtask

  task automatic play_run(input int n);
    logic [7:0] b[$];
    logic [7:0] e;
    int         r0;
    for (int i = 0; i < n; i++) begin
      e = 8'($urandom);
      b.push_back(e);
      fq.push_back(e);
    end
    gap(2);
    r0 = rd_cnt;
    for (int c = 0; c <= 8 * n + 3; c++) begin
      if (c > 0) step();
      play_en = 1'b1;
      @(negedge clk);
      e = exp_dac;
      for (int k = 0; k < n; k++) if (c >= 11 + DIV * k) e = b[k];
      check("play_dac", dac_val, e);
    end
    step();
    play_en = 1'b0;
    @(negedge clk);
    check("play_reads", rd_cnt - r0, n);
    exp_dac = b[n-1];
  endtask

  task automatic collide(input logic [7:0] a, input logic [7:0] h);
    fq.push_back(a);
    fq.push_back(h);
    gap(2);
    for (int c = 0; c <= 16; c++) begin
      if (c > 0) step();
      play_en = (c <= 12);
      host_rd = (c == 7);
      @(negedge clk);
      check("col_dac", dac_val, (c >= 11) ? a : exp_dac);
      check("col_hvalid", host_valid, c == 14);
      if (c == 14) check("col_hdata", host_data, h);
    end
    exp_dac = a;
  endtask

  task automatic disable_mid();
    logic [7:0] x, y;
    x = 8'($urandom);
    y = 8'($urandom);
    fq.push_back(x);
    fq.push_back(y);
    gap(2);
    for (int c = 0; c <= 32; c++) begin
      if (c > 0) step();
      play_en = (c < 9) || (c >= 20 && c <= 31);
      @(negedge clk);
      check("dis_dac", dac_val, (c >= 31) ? y : ((c >= 11) ? x : exp_dac));
      check("dis_rd", fifo_rd, (c == 9) || (c == 29));
    end
    exp_dac = y;
  endtask

  task automatic underrun_run();
    int ec;
    int r0;
    ec = 0;
    r0 = rd_cnt;
    for (int c = 0; c <= 2410; c++) begin
      if (c > 0) step();
      play_en      = 1'b1;
      underrun_clr = (c <= 8);
      @(negedge clk);
      check("urun_cnt", underrun_cnt, ec);
      check("urun_dac", dac_val, (MUTE && c >= 9) ? MID : exp_dac);
      if (underrun_clr) ec = 0;
      else if (c >= 8 && (c % DIV) == 0 && ec < 255) ec++;
    end
    step();
    play_en      = 1'b0;
    underrun_clr = 1'b0;
    @(negedge clk);
    check("urun_sat", underrun_cnt, 255);
    check("urun_no_rd", rd_cnt - r0, 0);
    step();
    underrun_clr = 1'b1;
    step();
    underrun_clr = 1'b0;
    @(negedge clk);
    check("urun_clr", underrun_cnt, 0);
    if (MUTE) exp_dac = MID;
  endtask

  task automatic reset_mid(input logic [7:0] b);
    fq.push_back(b);
    gap(2);
    for (int c = 0; c <= 8; c++) begin
      if (c > 0) step();
      host_rd = (c == 0);
      rst     = (c == 2) || (c == 3);
      @(negedge clk);
      if (c >= 3) begin
        check("rstm_fifo_rd", fifo_rd, 0);
        check("rstm_hvalid", host_valid, 0);
        check("rstm_busy", busy, 0);
        check("rstm_dac", dac_val, MID);
      end
    end
    exp_dac = MID;
  endtask

  initial begin
    rst          = 1'b1;
    play_en      = 1'b0;
    host_rd      = 1'b0;
    underrun_clr = 1'b0;
    exp_dac      = MID;
    gap(2);
    rst = 1'b0;
    @(negedge clk);
    check("rst_dac", dac_val, MID);
    check("rst_urun", underrun_cnt, 0);
    check("rst_fifo_rd", fifo_rd, 0);
    check("rst_busy", busy, 0);
    check("rst_hvalid", host_valid, 0);
    check("rst_hdata", host_data, 0);

    host_once(8'h5A);
    for (int i = 0; i < 4; i++) begin
      gap($urandom_range(1, 5));
      host_once(8'($urandom));
    end
    for (int i = 0; i < 2; i++) begin
      gap($urandom_range(1, 5));
      play_run($urandom_range(2, 5));
    end
    gap(2);
    collide(8'hA1, 8'hB2);
    for (int i = 0; i < 2; i++) begin
      gap($urandom_range(1, 5));
      collide(8'($urandom), 8'($urandom));
    end
    gap($urandom_range(1, 5));
    disable_mid();
    gap(3);
    underrun_run();
    gap(3);
    reset_mid(8'($urandom));
    gap(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sd_stream_player.md
# sd_stream_player

Playback scheduler for the SD read FIFO. It paces sample reads at a fixed audio rate and drives the 8-bit value fed to `pwm_dac`. It shares the single FIFO read port between the playback engine and byte reads requested by `spi_link_sm`. It sits between `sdc_controller` (FIFO side) and `spi_link_sm`/`pwm_dac`, and replaces the direct debug tap into the DAC.

## Interface
Parameters:
- `SAMPLE_DIV`, default 1134: clk cycles per sample period; legal range 4..65535.
- `DIV_W`, default 16: width of the divider counter.
- `MID_VAL`, default 8'h80: DAC midpoint, used as the reset value and the mute value.

Ports:
- `clk` in 1: system clock; the only clock.
- `rst` in 1: reset, synchronous, active-high.
- `play_en` in 1: playback enable, level.
- `host_rd` in 1: single-cycle read request from `spi_link_sm`.
- `host_data` out 8: byte returned to the host.
- `host_valid` out 1: one-cycle strobe; `host_data` is valid while it is high.
- `fifo_empty` in 1: SD read FIFO empty.
- `fifo_rd` out 1: FIFO read strobe, to `rd_en_i`.
- `fifo_data` in 8: FIFO read data, from `rd_dat_o`; valid on the cycle after `fifo_rd`.
- `dac_val` out 8: sample value to `pwm_dac.val`.
- `underrun_cnt` out 8: saturating count of missed samples.
- `underrun_clr` in 1: clears `underrun_cnt`.
- `busy` out 1: high whenever the FSM is not in IDLE.

## Operation
- Divider:
  - Counter runs 0..SAMPLE_DIV-1 only while `play_en`=1.
  - `tick` fires when the count equals SAMPLE_DIV-1, then the counter wraps to 0.
  - `play_en`=0 holds the counter at 0.
- Pending flags (registered):
  - `samp_pend` is set by `tick`.
  - `host_pend` is set by `host_rd`.
  - A `host_rd` arriving while `host_pend`=1 is ignored.
  - `play_en`=0 clears `samp_pend`.
- FSM states: IDLE, REQ_PLAY, CAP_PLAY, REQ_HOST, CAP_HOST.
- IDLE, priority order:
  1. `samp_pend` & `play_en` & !`fifo_empty`: go to REQ_PLAY and clear `samp_pend`.
  2. `samp_pend` & `play_en` & `fifo_empty`: underrun. Clear `samp_pend`, increment `underrun_cnt`, stay in IDLE.
  3. `host_pend` & !`fifo_empty`: go to REQ_HOST and clear `host_pend`.
  4. `host_pend` & `fifo_empty`: wait in IDLE. Host requests never time out.
- REQ_PLAY and REQ_HOST: `fifo_rd`=1 for exactly this cycle, then advance to CAP_PLAY or CAP_HOST.
- CAP_PLAY: load `dac_val` from `fifo_data`, return to IDLE.
- CAP_HOST: load `host_data` from `fifo_data`, pulse `host_valid` on the next cycle, return to IDLE.
- Missed deadline: a `tick` while `samp_pend` is still 1 also increments `underrun_cnt`; `samp_pend` stays 1.
- `underrun_cnt` saturates at 255. If `underrun_clr` and an increment occur in the same cycle, clear wins and the result is 0.
- `play_en` falling mid-read: an in-flight REQ_PLAY/CAP_PLAY completes normally and updates `dac_val`. After that, `dac_val` holds its value.
- `fifo_rd` is never asserted while `fifo_empty`=1 was sampled in IDLE. At most one read is outstanding at any time.

## Timing
- Reset values:
  - `fifo_rd`=0, `host_valid`=0, `host_data`=0, `underrun_cnt`=0, `busy`=0, `dac_val`=MID_VAL.
  - FSM in IDLE, both pending flags cleared, divider at 0.
- Reset asserted mid-operation aborts any state immediately. No further `fifo_rd` is issued.
- Host latency, with `host_rd` at cycle 0 and FIFO non-empty, block otherwise idle:
  - cycle 1: `host_pend`=1
  - cycle 2: `fifo_rd`=1
  - cycle 3: CAP_HOST
  - cycle 4: `host_valid`=1 with data
- Playback latency: `tick` at cycle 0 gives `fifo_rd` at cycle 2 and the new `dac_val` visible at cycle 4.
- Simultaneous `tick` and `host_rd`: the playback read is serviced first. The host read starts at the next IDLE, so `host_valid` arrives 3 cycles later than in the uncontended case.
- `underrun_cnt` updates one cycle after the cause is detected.

## Configuration
- `PLAYER_UNDERRUN_MUTE_EN`:
  - Defined: every underrun also loads `dac_val` with MID_VAL in the same update as the counter increment.
  - Undefined: `dac_val` holds the last played sample on underrun.
  - All other behaviour is identical either way.

## Test plan
- Reset: hold `rst` 2 cycles. Required: `dac_val`=8'h80, `underrun_cnt`=0, `fifo_rd`=0, `busy`=0.
- Host read, FIFO holding 8'h5A, `play_en`=0: pulse `host_rd` at cycle 0. Required: `fifo_rd` only at cycle 2, `host_valid` at cycle 4 with `host_data`=8'h5A.
- Playback, SAMPLE_DIV=8, FIFO holding 8'h10, 8'h20, 8'h30: `play_en`=1. Required: `dac_val` steps 10→20→30 exactly 8 cycles apart, one `fifo_rd` per step.
- Collision: `tick` and `host_rd` in the same cycle, FIFO holding A1, B2. Required: `dac_val`=A1 and `host_data`=B2, with `host_valid` 3 cycles later than the uncontended case.
- Underrun: `play_en`=1 with FIFO empty for 300 ticks. Required:
  - `underrun_cnt` saturates at 255 and `fifo_rd` is never asserted.
  - `dac_val` is 8'h80 with the macro defined, and the prior sample without it.
  - `underrun_clr` then returns the count to 0.
- Disable mid-read: drop `play_en` in the REQ_PLAY cycle. Required: `dac_val` still loads, no further reads occur, and the divider reads 0.
